uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  - UART receive front end: oversamples async serial line rx, deserializes one frame
//    (start, DATA_BITS data LSB-first, optional parity, 1 stop) into a parallel word.
//  - Sits directly upstream of the 4-bit holding register stage. data_out drives its D,
//    data_valid gates its clock-enable/load.
//  - One-cycle valid strobe per good frame. Error flags for framing/parity.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); must be >= 4
//  DATA_BITS     8    data bits per frame, 4..8
//  PARITY_ODD    0    0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)
// PORTS
//  clk         in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high reset
//  rx          in   1          asynchronous serial line, idle high
//  data_out    out  DATA_BITS  last correctly received word, held until next good frame
//  data_valid  out  1          1-cycle pulse: data_out updated this cycle
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  parity_err  out  1          1-cycle pulse: parity mismatch (constant 0 if feature off)
//  busy        out  1          high from start-edge detect until return to IDLE
// BEHAVIOUR
//  - Reset: data_out=0, data_valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE,
//    synchronizer flops preset to 1, bit/clk counters 0. Reset mid-frame aborts it; no strobe.
//  - rx passes through 2-FF synchronizer (rx_s); all decisions use rx_s only.
//  - Counters: clk_cnt 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); bit_cnt 0..DATA_BITS-1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//   IDLE  : rx_s==0 -> START, clk_cnt=0, busy=1.
//   START : at clk_cnt==CLKS_PER_BIT/2-1 (mid start bit): rx_s==1 -> IDLE (glitch, no flag);
//           rx_s==0 -> DATA, clk_cnt=0, bit_cnt=0.
//   DATA  : at clk_cnt==CLKS_PER_BIT-1 sample rx_s into shift reg (LSB first), clk_cnt=0;
//           after bit_cnt==DATA_BITS-1 -> PARITY (feature on) or STOP (feature off).
//   PARITY: sample at clk_cnt==CLKS_PER_BIT-1, latch mismatch internally -> STOP.
//   STOP  : sample at clk_cnt==CLKS_PER_BIT-1. Result is registered on the next clk edge:
//           rx_s==1, no parity mismatch -> data_out=shift reg, data_valid=1 -> IDLE.
//           rx_s==1, parity mismatch    -> parity_err=1, data_out held -> IDLE.
//           rx_s==0 -> frame_err=1, data_out held -> BREAK.
//   BREAK : wait until rx_s==1, then -> IDLE (line held low is not re-read as start).
//  - Latency: data_valid rises 1 clk after stop-bit mid sample
//    (~ (DATA_BITS+1.5)*CLKS_PER_BIT + 3 clks after rx falling edge incl. synchronizer).
//  - Strobes are mutually exclusive and never exceed 1 cycle. busy drops in the same
//    cycle as the strobe. IDLE accepts a new start edge in the next cycle (back-to-back
//    frames with zero idle time must be received).
//  - rx edges between sample points are ignored. No resynchronization mid-frame.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: PARITY state present. Parity bit compared against
//    XOR of data (^ PARITY_ODD). Mismatch -> parity_err pulse instead of data_valid.
//  - Not defined: PARITY state and logic absent, STOP follows last data bit,
//    parity_err tied 0, PARITY_ODD ignored.
// TESTING  (sim with CLKS_PER_BIT=16, DATA_BITS=8)
//  1. Reset then frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop=1 -> data_valid 1 clk,
//     data_out=8'hA5, frame_err=0, busy low same cycle.
//  2. Back-to-back 0x00 then 0xFF, no idle bits -> two data_valid pulses,
//     data_out 8'h00 then 8'hFF.
//  3. rx low pulse of 4 clks in IDLE -> return to IDLE at mid-start, no strobe,
//     data_out unchanged.
//  4. Frame 0x3C with stop=0, rx held low 40 clks -> frame_err 1 clk, data_out keeps
//     prior value, no start detected until rx high; next 0x81 frame -> data_out=8'h81.
//  5. reset asserted at mid data bit 4 of 0x5A -> all outputs 0 immediately; next full
//     frame 0x12 received correctly.
//  6. UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity=1 -> data_valid, 8'h07;
//     parity=0 -> parity_err 1 clk, data_valid stays 0.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-FF synchronizer, oversampled start/data/stop deserializer.
// Define UART_RX_PARITY_EN to add a parity bit check between data and stop.
`timescale 1ns/1ps
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 tick;
  logic                 mid_start;
  logic                 cnt_run;
  logic                 dv_d;
  logic                 fe_d;
  logic                 pe_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  assign tick      = (clk_cnt == LAST);
  assign mid_start = (state == START) && (clk_cnt == HALF);
  assign cnt_run   = (state != IDLE) && (state != BRK);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: if (mid_start) state_n = rx_s ? IDLE : DATA;
      DATA:
        if (tick && bit_cnt == BLAST)
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_n = STOP;
`endif
      STOP:  if (tick) state_n = rx_s ? IDLE : BRK;
      BRK:   if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dv_d = 1'b0;
    fe_d = 1'b0;
    pe_d = 1'b0;
    busy = (state != IDLE);
    if (state == STOP && tick) begin
      fe_d = !rx_s;
      dv_d = rx_s && !par_bad;
      pe_d = rx_s && par_bad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= dv_d;
      frame_err  <= fe_d;
      if (dv_d) data_out <= shreg;
      if (!cnt_run || tick || mid_start) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;
      if (state == START) bit_cnt <= '0;
      else if (state == DATA && tick)
        bit_cnt <= (bit_cnt == BLAST) ? '0 : bit_cnt + 1'b1;
      if (state == DATA && tick)
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Mismatch is held until the stop bit decides which strobe fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= pe_d;
      if (state == START) par_bad <= 1'b0;
      else if (state == PARITY && tick)
        par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = pe_d & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frame-level model predicts every output
// cycle by cycle; directed scenarios plus randomized frames and glitches.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int CPB  = 16;
  localparam int DB   = 8;
  localparam bit ODD  = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int P       = 1;
  localparam int LAT_LIT = 171;
`else
  localparam int P       = 0;
  localparam int LAT_LIT = 155;
`endif
  localparam int LAT  = 3 + CPB / 2 + (DB + 1 + P) * CPB;
  localparam int MAXC = 40000;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .PARITY_ODD  (ODD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  bit         exp_dv  [MAXC];
  bit         exp_fe  [MAXC];
  bit         exp_pe  [MAXC];
  bit         exp_busy[MAXC];
  logic [7:0] exp_word[MAXC];

  logic [7:0] model_word   = 8'h00;
  logic [7:0] last_dv_data = 8'h00;
  int         last_dv_cyc  = -1;
  int         last_fe_cyc  = -1;
  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      model_word = 8'h00;
    end else if (cyc < MAXC) begin
      if (exp_dv[cyc]) model_word = exp_word[cyc];
      chk("data_valid", int'(data_valid), int'(exp_dv[cyc]));
      chk("frame_err", int'(frame_err), int'(exp_fe[cyc]));
      chk("parity_err", int'(parity_err), int'(exp_pe[cyc]));
      chk("busy", int'(busy), int'(exp_busy[cyc]));
      chk("data_out", int'(data_out), int'(model_word));
      if (data_valid) begin
        dv_cnt++;
        last_dv_cyc  = cyc;
        last_dv_data = data_out;
      end
      if (frame_err) begin
        fe_cnt++;
        last_fe_cyc = cyc;
      end
      if (parity_err) pe_cnt++;
    end
  end

  function automatic logic gp(input logic [7:0] d);
    return (^d) ^ ODD;
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i <= b; i++)
      if (i >= 0 && i < MAXC) exp_busy[i] = 1'b1;
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Result lands LAT cycles after the start bit is driven.
  task automatic send(input logic [7:0] d, input logic stop_v,
                      input logic par_v, input int hold);
    int k;
    int s;
    int h;
    k = cyc;
    s = k + LAT;
    mark_busy(k + 3, s - 1);
    if (s < MAXC) begin
      if (stop_v) begin
        if (P == 1 && par_v != gp(d)) exp_pe[s] = 1'b1;
        else begin
          exp_dv[s]   = 1'b1;
          exp_word[s] = d;
        end
      end else begin
        exp_fe[s] = 1'b1;
        h = k + (DB + 2 + P) * CPB + hold;
        mark_busy(s, h + 2);
      end
    end
    hold_rx(1'b0, CPB);
    for (int i = 0; i < DB; i++) hold_rx(d[i], CPB);
    if (P == 1) hold_rx(par_v, CPB);
    hold_rx(stop_v, CPB);
    if (!stop_v) begin
      hold_rx(1'b0, hold);
      hold_rx(1'b1, 2);
    end
  endtask

  task automatic glitch(input int w);
    int k;
    k = cyc;
    mark_busy(k + 3, k + 2 + CPB / 2);
    hold_rx(1'b0, w);
    hold_rx(1'b1, CPB - w);
  endtask

  task automatic abort_frame(input logic [7:0] d);
    int k;
    int a;
    k = cyc;
    a = 5 * CPB + CPB / 2;
    mark_busy(k + 3, k + a - 1);
    hold_rx(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_rx(d[i], CPB);
    hold_rx(d[4], CPB / 2);
    reset = 1'b1;
    #1;
    chk("t5_rst_data_out", int'(data_out), 0);
    chk("t5_rst_valid", int'(data_valid), 0);
    chk("t5_rst_busy", int'(busy), 0);
    rx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    int k0;
    int n0;
    int p0;
    int r;
    logic [7:0] d;
    logic sv;
    reset = 1'b0;
    rx    = 1'b1;
    #1 reset = 1'b1;
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    hold_rx(1'b1, 5);

    k0 = cyc;
    send(8'hA5, 1'b1, gp(8'hA5), 0);
    chk("t1_latency", last_dv_cyc - k0, LAT_LIT);
    chk("t1_word", int'(last_dv_data), 8'hA5);

    n0 = dv_cnt;
    send(8'h00, 1'b1, gp(8'h00), 0);
    chk("t2_word0", int'(last_dv_data), 8'h00);
    send(8'hFF, 1'b1, gp(8'hFF), 0);
    chk("t2_word1", int'(last_dv_data), 8'hFF);
    chk("t2_count", dv_cnt - n0, 2);
    hold_rx(1'b1, 4);

    n0 = dv_cnt + fe_cnt + pe_cnt;
    glitch(4);
    hold_rx(1'b1, 4);
    chk("t3_no_strobe", dv_cnt + fe_cnt + pe_cnt - n0, 0);
    chk("t3_word", int'(data_out), 8'hFF);

    k0 = cyc;
    send(8'h3C, 1'b0, gp(8'h3C), 40);
    chk("t4_fe_latency", last_fe_cyc - k0, LAT_LIT);
    chk("t4_word_held", int'(data_out), 8'hFF);
    send(8'h81, 1'b1, gp(8'h81), 0);
    chk("t4_word_next", int'(last_dv_data), 8'h81);
    hold_rx(1'b1, 3);

    abort_frame(8'h5A);
    hold_rx(1'b1, 5);
    send(8'h12, 1'b1, gp(8'h12), 0);
    chk("t5_word", int'(last_dv_data), 8'h12);

`ifdef UART_RX_PARITY_EN
    n0 = dv_cnt;
    p0 = pe_cnt;
    send(8'h07, 1'b1, 1'b1, 0);
    chk("t6_word", int'(last_dv_data), 8'h07);
    send(8'h07, 1'b1, 1'b0, 0);
    chk("t6_pe", pe_cnt - p0, 1);
    chk("t6_dv", dv_cnt - n0, 1);
`endif

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch($urandom_range(1, CPB / 2 - 1));
      end else begin
        d  = 8'($urandom);
        sv = (r != 1);
        send(d, sv, gp(d) ^ ($urandom_range(0, 3) == 0),
             $urandom_range(0, 40));
        hold_rx(1'b1, $urandom_range(0, 2 * CPB));
      end
    end
    hold_rx(1'b1, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
